inst_axi_rd_bridge: RTL and testbench

- Converts the instruction-fetch SRAM-like port into AXI4 read-address (AR) and read-data (R) channel traffic. The port is driven by the pre-IF/IF stage: req, addr, addr_ok, data_ok, rdata.
- Sits between the fetch stage and the CPU top-level AXI interface.
- Supports up to MAX_OUTS in-order outstanding reads, which matches the fetch stage's two-deep abandon/instruction buffering.
- Single-beat, 32-bit, read-only.

---
 rtl/inst_axi_rd_bridge_pkg.sv | 19 +
 rtl/inst_axi_rd_bridge_if.sv | 57 +++++
 rtl/inst_axi_rd_bridge.sv | 102 ++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// rtl/inst_axi_rd_bridge_pkg.sv - shared AR state encodings and AXI read constants
//
// Holds the AR-channel state encodings and the fixed AXI attribute values
// used by the instruction-fetch read bridge and the later data-port bridge.
package inst_axi_rd_bridge_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    // AR channel state encodings
    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_BUSY = 1'b1;

    // Fixed AXI read attributes: single beat, 4-byte, incrementing
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_1      = 8'd0;

endpackage

// File: rtl/inst_axi_rd_bridge_if.sv
// rtl/inst_axi_rd_bridge_if.sv - fetch SRAM-like port plus AXI AR/R channels
//
// Signals:
//   inst_sram_req/addr         fetch stage -> bridge request
//   inst_sram_addr_ok          request accepted this cycle
//   inst_sram_data_ok/rdata    returned instruction word
//   arid..arvalid, arready     AXI read-address channel
//   rid, rdata, rresp, rlast, rvalid, rready   AXI read-data channel
// Modports:
//   master - the bridge (drives AR, rready and the SRAM-side responses)
//   slave  - the environment (fetch stage and AXI slave)
interface inst_axi_rd_bridge_if;
    import inst_axi_rd_bridge_pkg::*;

    logic        inst_sram_req;
    addr_t       inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    word_t       inst_sram_rdata;

    logic [3:0]  arid;
    addr_t       araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    word_t       rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_sram_req, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_sram_req, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/inst_axi_rd_bridge.sv
// rtl/inst_axi_rd_bridge.sv - instruction-fetch SRAM-like port to AXI4 read bridge
//
// Converts single-beat 32-bit fetch requests into AXI AR/R traffic with up to
// MAX_OUTS in-order outstanding reads.
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset
//   bus     inst_axi_rd_bridge_if.master (fetch port + AXI AR/R channels)
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter logic [3:0] ARID_VAL = 4'd0,
    parameter int         MAX_OUTS = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    inst_axi_rd_bridge_if.master     bus
);

    localparam int                CNT_W   = $clog2(MAX_OUTS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTS);

    logic [0:0]       r_ar_state;
    addr_t            r_araddr;
    logic             r_arvalid;
    logic [CNT_W-1:0] r_outs_cnt;
    logic             r_rready;

    logic             w_addr_ok;
    logic             w_ar_acc;
    logic             w_r_done;
    logic             w_unused_ok;

    // Gated by resetn so the fetch stage sees no acceptance while reset is held.
    assign w_addr_ok = (r_ar_state == AR_IDLE) && (r_outs_cnt < MAX_CNT) && resetn;
    assign w_ar_acc  = bus.inst_sram_req && w_addr_ok;
    assign w_r_done  = bus.rvalid && r_rready && bus.rlast;

    // Single ID with in-order return makes rid/rresp irrelevant here.
    assign w_unused_ok = ^{bus.rid, bus.rresp};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ar_state <= AR_IDLE;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            r_rready <= 1'b1;
            case (r_ar_state)
                AR_IDLE: begin
                    if (w_ar_acc) begin
                        r_ar_state <= AR_BUSY;
                        r_araddr   <= bus.inst_sram_addr;
                        r_arvalid  <= 1'b1;
                    end
                end
                AR_BUSY: begin
                    if (r_arvalid && bus.arready) begin
                        r_ar_state <= AR_IDLE;
                        r_arvalid  <= 1'b0;
                    end
                end
                default: begin
                    r_ar_state <= AR_IDLE;
                    r_arvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Accept and completion in the same cycle cancel out; a completion with
    // nothing outstanding is illegal and the counter holds at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_outs_cnt <= '0;
        end else if (w_ar_acc && !w_r_done) begin
            r_outs_cnt <= r_outs_cnt + 1'b1;
        end else if (w_r_done && !w_ar_acc && (r_outs_cnt != '0)) begin
            r_outs_cnt <= r_outs_cnt - 1'b1;
        end
    end

    a_no_spurious_r: assert property (@(posedge clk) disable iff (!resetn)
        !(w_r_done && (r_outs_cnt == '0)));

    assign bus.inst_sram_addr_ok = w_addr_ok;
    assign bus.inst_sram_data_ok = w_r_done;
    assign bus.inst_sram_rdata   = bus.rdata;

    assign bus.arid    = ARID_VAL;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = AXI_LEN_1;
    assign bus.arsize  = AXI_SIZE_4B;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = r_rready;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// tb/tb_inst_axi_rd_bridge.sv - self-checking bench for inst_axi_rd_bridge
module tb_inst_axi_rd_bridge;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    inst_axi_rd_bridge_if bus();

    inst_axi_rd_bridge #(.ARID_VAL(4'd0), .MAX_OUTS(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ar_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hbfc00000) return 32'h3c08bfaf;
        return {a[15:0] ^ 16'h5a5a, a[31:16]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic r_return();
        if (ar_q.size() != 0) bus.rdata = mem(ar_q.pop_front());
        else                  bus.rdata = 32'h0;
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        bus.rid    = 4'($urandom);
        bus.rresp  = 2'($urandom);
    endtask

    task automatic r_idle();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rdata  = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.rvalid = 1'b1; bus.rlast = 1'b1;
        bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'hdeadbeef;
        tick(); tick(); #1;
        n_vec++; if (bus.arvalid !== 1'b0 || bus.araddr !== 32'h0) begin n_bad++; $display("FAIL reset_ar: arvalid=%b araddr=%h want 0/0", bus.arvalid, bus.araddr); end
        n_vec++; if (bus.rready !== 1'b0 || bus.inst_sram_addr_ok !== 1'b0 || bus.inst_sram_data_ok !== 1'b0) begin n_bad++; $display("FAIL reset_hs: rready=%b addr_ok=%b data_ok=%b want 000", bus.rready, bus.inst_sram_addr_ok, bus.inst_sram_data_ok); end
        n_vec++; if ({bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot} !== {4'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0}) begin n_bad++; $display("FAIL reset_consts: got %h", {bus.arid, bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot}); end
        r_idle();
        bus.inst_sram_req = 1'b0;
        resetn = 1'b1;
        tick(); #1;
        n_vec++; if (bus.rready !== 1'b1 || bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL reset_release: rready=%b addr_ok=%b want 1/1", bus.rready, bus.inst_sram_addr_ok); end
        n_vec++; if (dut.r_outs_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", dut.r_outs_cnt); end
    endtask

    task automatic test_single_fetch();
        logic [31:0] exp_w;
        tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'hbfc00000; #1;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL single_addr_ok: got %b want 1", bus.inst_sram_addr_ok); end
        exp_q.push_back(mem(32'hbfc00000));
        tick(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1; #1;
        n_vec++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'hbfc00000) begin n_bad++; $display("FAIL single_ar: arvalid=%b araddr=%h want 1/bfc00000", bus.arvalid, bus.araddr); end
        ar_q.push_back(bus.araddr);
        tick(); bus.arready = 1'b0; #1;
        n_vec++; if (bus.arvalid !== 1'b0 || bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL single_after_ar: arvalid=%b addr_ok=%b want 0/1", bus.arvalid, bus.inst_sram_addr_ok); end
        tick();
        tick(); r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL single_data: data_ok=%b rdata=%h want 1/%h", bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        tick(); r_idle(); #1;
        n_vec++; if (dut.r_outs_cnt !== 2'd0 || bus.inst_sram_data_ok !== 1'b0) begin n_bad++; $display("FAIL single_done: cnt=%0d data_ok=%b want 0/0", dut.r_outs_cnt, bus.inst_sram_data_ok); end
    endtask

    task automatic test_ar_backpressure();
        logic [31:0] exp_w;
        tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'hbfc00004; #1;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL bp_addr_ok: got %b want 1", bus.inst_sram_addr_ok); end
        exp_q.push_back(mem(32'hbfc00004));
        for (int c = 1; c <= 4; c++) begin
            tick(); bus.inst_sram_req = 1'b0; bus.arready = (c == 4); #1;
            n_vec++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'hbfc00004 || bus.inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL bp_hold_c%0d: arvalid=%b araddr=%h addr_ok=%b want 1/bfc00004/0", c, bus.arvalid, bus.araddr, bus.inst_sram_addr_ok); end
            if (c == 4) ar_q.push_back(bus.araddr);
        end
        tick(); bus.arready = 1'b0; #1;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b1 || bus.arvalid !== 1'b0) begin n_bad++; $display("FAIL bp_release: addr_ok=%b arvalid=%b want 1/0", bus.inst_sram_addr_ok, bus.arvalid); end
        tick(); r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL bp_data: data_ok=%b rdata=%h want 1/%h", bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        tick(); r_idle();
    endtask

    task automatic test_outstanding_limit();
        logic [31:0] exp_w;
        logic [31:0] a [3];
        a[0] = 32'h80001000; a[1] = 32'h80001004; a[2] = 32'h80001008;
        for (int i = 0; i < 2; i++) begin
            tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = a[i]; #1;
            n_vec++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL lim_accept%0d: got %b want 1", i, bus.inst_sram_addr_ok); end
            exp_q.push_back(mem(a[i]));
            tick(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1; #1;
            n_vec++; if (bus.araddr !== a[i]) begin n_bad++; $display("FAIL lim_araddr%0d: got %h want %h", i, bus.araddr, a[i]); end
            ar_q.push_back(bus.araddr);
        end
        tick(); bus.arready = 1'b0; bus.inst_sram_req = 1'b1; bus.inst_sram_addr = a[2]; #1;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b0 || dut.r_outs_cnt !== 2'd2) begin n_bad++; $display("FAIL lim_full: addr_ok=%b cnt=%0d want 0/2", bus.inst_sram_addr_ok, dut.r_outs_cnt); end
        tick(); r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b0 || bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL lim_first: addr_ok=%b data_ok=%b rdata=%h want 0/1/%h", bus.inst_sram_addr_ok, bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        tick(); r_idle(); #1;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL lim_reopen: got %b want 1", bus.inst_sram_addr_ok); end
        exp_q.push_back(mem(a[2]));
        tick(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1; #1;
        n_vec++; if (bus.araddr !== a[2]) begin n_bad++; $display("FAIL lim_araddr2: got %h want %h", bus.araddr, a[2]); end
        ar_q.push_back(bus.araddr);
        for (int i = 0; i < 2; i++) begin
            tick(); bus.arready = 1'b0; r_return(); #1;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL lim_order%0d: data_ok=%b rdata=%h want 1/%h", i, bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        end
        tick(); r_idle(); #1;
        n_vec++; if (dut.r_outs_cnt !== 2'd0) begin n_bad++; $display("FAIL lim_drain: cnt=%0d want 0", dut.r_outs_cnt); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_w;
        tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h00400020; #1;
        exp_q.push_back(mem(32'h00400020));
        tick(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1; #1;
        ar_q.push_back(bus.araddr);
        tick(); bus.arready = 1'b0; bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h00400024; r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b1 || bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL sim_both: addr_ok=%b data_ok=%b rdata=%h want 1/1/%h", bus.inst_sram_addr_ok, bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        exp_q.push_back(mem(32'h00400024));
        tick(); bus.inst_sram_req = 1'b0; r_idle(); bus.arready = 1'b1; #1;
        n_vec++; if (dut.r_outs_cnt !== 2'd1 || bus.inst_sram_data_ok !== 1'b0 || bus.araddr !== 32'h00400024) begin n_bad++; $display("FAIL sim_after: cnt=%0d data_ok=%b araddr=%h want 1/0/00400024", dut.r_outs_cnt, bus.inst_sram_data_ok, bus.araddr); end
        ar_q.push_back(bus.araddr);
        tick(); bus.arready = 1'b0; r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL sim_second: data_ok=%b rdata=%h want 1/%h", bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        tick(); r_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_w;
        tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h00001100; #1;
        exp_q.push_back(mem(32'h00001100));
        tick(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1; #1;
        ar_q.push_back(bus.araddr);
        tick(); bus.arready = 1'b0; bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h00001104; #1;
        exp_q.push_back(mem(32'h00001104));
        tick(); bus.inst_sram_req = 1'b0; #1;
        n_vec++; if (bus.arvalid !== 1'b1 || dut.r_outs_cnt !== 2'd2) begin n_bad++; $display("FAIL rmid_pre: arvalid=%b cnt=%0d want 1/2", bus.arvalid, dut.r_outs_cnt); end
        resetn = 1'b0; #1;
        n_vec++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || dut.r_outs_cnt !== 2'd0 || bus.inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL rmid_async: arvalid=%b rready=%b cnt=%0d addr_ok=%b want 0/0/0/0", bus.arvalid, bus.rready, dut.r_outs_cnt, bus.inst_sram_addr_ok); end
        exp_q.delete(); ar_q.delete();
        tick(); tick(); resetn = 1'b1;
        tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h00002200; #1;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b1 || bus.rready !== 1'b1) begin n_bad++; $display("FAIL rmid_first: addr_ok=%b rready=%b want 1/1", bus.inst_sram_addr_ok, bus.rready); end
        exp_q.push_back(mem(32'h00002200));
        tick(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1; #1;
        ar_q.push_back(bus.araddr);
        tick(); bus.arready = 1'b0; r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL rmid_data: data_ok=%b rdata=%h want 1/%h", bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        tick(); r_idle();
    endtask

    task automatic test_req_withdrawal();
        logic [31:0] exp_w;
        tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'h00003300; #1;
        exp_q.push_back(mem(32'h00003300));
        tick(); bus.inst_sram_addr = 32'h0000dead; #1;
        n_vec++; if (bus.inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL wd_busy: addr_ok=%b want 0", bus.inst_sram_addr_ok); end
        tick(); bus.inst_sram_req = 1'b0; bus.arready = 1'b1; #1;
        n_vec++; if (bus.araddr !== 32'h00003300) begin n_bad++; $display("FAIL wd_araddr: got %h want 00003300", bus.araddr); end
        ar_q.push_back(bus.araddr);
        tick(); bus.arready = 1'b0; #1;
        n_vec++; if (bus.arvalid !== 1'b0 || dut.r_outs_cnt !== 2'd1 || bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL wd_state: arvalid=%b cnt=%0d addr_ok=%b want 0/1/1", bus.arvalid, dut.r_outs_cnt, bus.inst_sram_addr_ok); end
        tick(); r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL wd_data: data_ok=%b rdata=%h want 1/%h", bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        tick(); r_idle(); #1;
        n_vec++; if (bus.arvalid !== 1'b0 || dut.r_outs_cnt !== 2'd0) begin n_bad++; $display("FAIL wd_end: arvalid=%b cnt=%0d want 0/0", bus.arvalid, dut.r_outs_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w;
        logic [31:0] addr;
        bus.arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h1fc00100 + 32'(i * 4);
            tick(); bus.inst_sram_req = 1'b1; bus.inst_sram_addr = addr;
            if (i > 0) r_return(); else r_idle();
            #1;
            n_vec++; if (bus.inst_sram_addr_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_addr_ok%0d: got %b want 1", i, bus.inst_sram_addr_ok); end
            exp_q.push_back(mem(addr));
            if (i > 0) begin
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL b2b_data%0d: data_ok=%b rdata=%h want 1/%h", i, bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
            end
            tick(); bus.inst_sram_req = 1'b0; r_idle(); #1;
            n_vec++; if (bus.arvalid !== 1'b1 || bus.araddr !== addr || bus.inst_sram_addr_ok !== 1'b0) begin n_bad++; $display("FAIL b2b_ar%0d: arvalid=%b araddr=%h addr_ok=%b want 1/%h/0", i, bus.arvalid, bus.araddr, bus.inst_sram_addr_ok, addr); end
            ar_q.push_back(bus.araddr);
        end
        tick(); bus.arready = 1'b0; r_return(); #1;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++; if (bus.inst_sram_data_ok !== 1'b1 || bus.inst_sram_rdata !== exp_w) begin n_bad++; $display("FAIL b2b_last: data_ok=%b rdata=%h want 1/%h", bus.inst_sram_data_ok, bus.inst_sram_rdata, exp_w); end
        tick(); r_idle(); #1;
        n_vec++; if (dut.r_outs_cnt !== 2'd0 || exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: cnt=%0d pending=%0d want 0/0", dut.r_outs_cnt, exp_q.size()); end
    endtask

    initial begin
        bus.inst_sram_req  = 1'b0;
        bus.inst_sram_addr = 32'h0;
        bus.arready        = 1'b0;
        bus.rid            = 4'h0;
        bus.rresp          = 2'b00;
        r_idle();
        test_reset();
        test_single_fetch();
        test_ar_backpressure();
        test_outstanding_limit();
        test_simultaneous();
        test_reset_mid();
        test_req_withdrawal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
